// File: rtl/pool1_pkg.sv
// pool1_pkg: shared constants, FSM state enum and index helpers for the
// pool1_10 2x2 pool + binarize stage.
//   BW  - bits per popcount element
//   CH  - channels, IN - input side, OUT - pooled side, NWIN - windows per map
//   elem_base(c,y,x) - bit position of element MSB inside the flat fmap bus
//   out_idx(c,r,k)   - bit position of window result inside o_bin
package pool1_pkg;

  localparam int BW   = 8;
  localparam int CH   = 10;
  localparam int IN   = 24;
  localparam int OUT  = IN / 2;
  localparam int NWIN = CH * OUT * OUT;
  localparam int FW   = CH * IN * IN * BW;
  localparam int TW   = BW + 2;

  localparam int FIW  = $clog2(FW);
  localparam int OIW  = $clog2(NWIN);
  localparam int CW   = $clog2(CH);
  localparam int RW   = $clog2(OUT);

  localparam logic [CW-1:0] CMAX = CW'(CH - 1);
  localparam logic [RW-1:0] KMAX = RW'(OUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic [FIW-1:0] fidx_t;
  typedef logic [OIW-1:0] oidx_t;

  // Element (c,y,x) starts at this bit; that bit is the element's MSB.
  function automatic fidx_t elem_base(input int c, input int y, input int x);
    return fidx_t'(((c * IN + y) * IN + x) * BW);
  endfunction

  function automatic oidx_t out_idx(input int c, input int r, input int k);
    return oidx_t'((c * OUT + r) * OUT + k);
  endfunction

endpackage

// File: rtl/pool1_win.sv
// pool1_win: combinational reduction of one 2x2 window plus threshold compare.
//   elems - the four window elements (plain unsigned, LSB at bit 0)
//   thr   - binarization threshold, BW+2 bits
//   hit   - 1 when the reduced value m >= thr
// Build option: POOL1_SUM_EN defined -> m is the sum of the four elements;
// undefined -> m is their maximum. m is BW+2 bits wide in both builds, so
// the sum cannot overflow.
module pool1_win
  import pool1_pkg::*;
(
  input  logic [3:0][BW-1:0] elems,
  input  logic [TW-1:0]      thr,
  output logic               hit
);

  logic [TW-1:0] m;

  always_comb begin
    m = '0;
    for (int j = 0; j < 4; j++) begin
`ifdef POOL1_SUM_EN
      m = m + {2'b00, elems[j]};
`else
      if ({2'b00, elems[j]} > m) m = {2'b00, elems[j]};
`endif
    end
  end

  assign hit = (m >= thr);

endmodule

// File: rtl/pool1_10.sv
// pool1_10: sequential 2x2 pooling + re-binarization after conv layer 1.
// Walks the 10x24x24 map one window per cycle (k fastest, then r, then c)
// and writes one result bit per window into o_bin.
//   i_clk, i_rst_n      - clock, async active-low reset
//   i_fmap              - flat feature map, held stable by upstream for the run
//   i_valid / o_ready   - input handshake, o_ready high only in IDLE
//   i_threshold         - compare threshold (BW+2 bits, unsigned)
//   o_bin               - 10x12x12 binary map, bit (c*OUT+r)*OUT+k
//   o_valid / i_ready   - output handshake, o_valid high only in DONE
// Build option POOL1_SUM_EN selects sum pooling in pool1_win (default max).
module pool1_10
  import pool1_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [FW-1:0]   i_fmap,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [TW-1:0]   i_threshold,
  output logic [NWIN-1:0] o_bin,
  output logic            o_valid,
  input  logic            i_ready
);

  state_t        state, nstate;
  logic [CW-1:0] c;
  logic [RW-1:0] r, k;
  logic          last;
  logic          hit;
  oidx_t         oidx;

  logic [3:0][FIW-1:0] base;
  logic [3:0][BW-1:0]  win;

  // Tap j covers (2r + j/2, 2k + j%2).
  always_comb begin
    for (int j = 0; j < 4; j++)
      base[j] = elem_base(int'(c), 2 * int'(r) + (j / 2), 2 * int'(k) + (j % 2));
  end

  // The bus stores each element MSB-first, so flip bit order on the way in.
  for (genvar j = 0; j < 4; j++) begin : g_tap
    for (genvar i = 0; i < BW; i++) begin : g_bit
      assign win[j][BW-1-i] = i_fmap[base[j] + fidx_t'(i)];
    end
  end

  pool1_win u_win (
    .elems (win),
    .thr   (i_threshold),
    .hit   (hit)
  );

  assign oidx = out_idx(int'(c), int'(r), int'(k));
  assign last = (c == CMAX) && (r == KMAX) && (k == KMAX);

  always_comb begin
    nstate  = state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) nstate = RUN;
      end
      RUN: begin
        if (last) nstate = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      c     <= '0;
      r     <= '0;
      k     <= '0;
      o_bin <= '0;
    end else begin
      state <= nstate;
      case (state)
        IDLE: begin
          if (i_valid) begin
            c <= '0;
            r <= '0;
            k <= '0;
          end
        end
        RUN: begin
          o_bin[oidx] <= hit;
          if (k == KMAX) begin
            k <= '0;
            if (r == KMAX) begin
              r <= '0;
              c <= (c == CMAX) ? '0 : c + 1'b1;
            end else begin
              r <= r + 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pool1_10.sv
// tb_pool1_10: table-driven directed bench for pool1_10 plus hand-written
// sequences for DONE back-pressure, mid-run reset and back-to-back maps.
module tb_pool1_10;

  localparam int BW   = 8;
  localparam int CH   = 10;
  localparam int IN   = 24;
  localparam int OUT  = 12;
  localparam int NB   = CH * OUT * OUT;
  localparam int FW   = CH * IN * IN * BW;
  localparam int LAT  = 1441;

  logic            i_clk;
  logic            i_rst_n;
  logic [FW-1:0]   i_fmap;
  logic            i_valid;
  logic            o_ready;
  logic [BW+1:0]   i_threshold;
  logic [NB-1:0]   o_bin;
  logic            o_valid;
  logic            i_ready;

  logic [NB-1:0]   exp_bin;
  int checks = 0;
  int errors = 0;

  pool1_10 dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_fmap      (i_fmap),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_threshold (i_threshold),
    .o_bin       (o_bin),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string nm;
    int    c, y, x, v;
    bit    quad;   // set the whole 2x2 block at (c,y,x) to v
    int    thr;
    bit    all1;   // expected o_bin all ones
    int    eidx;   // single expected set bit, -1 for none
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  task automatic chk_bin(input string nm);
    int first;
    checks++;
    if (o_bin !== exp_bin) begin
      errors++;
      first = -1;
      for (int i = 0; i < NB; i++)
        if (first < 0 && o_bin[i] !== exp_bin[i]) first = i;
      $display("FAIL %s o_bin first diff bit %0d got %b exp %b, ones got %0d exp %0d",
               nm, first, o_bin[first], exp_bin[first], $countones(o_bin), $countones(exp_bin));
    end
  endtask

  // Element (c,y,x): bit b is MSB, bit b+BW-1 is LSB.
  task automatic set_elem(input int c, input int y, input int x, input int v);
    int b;
    b = ((c * IN + y) * IN + x) * BW;
    for (int i = 0; i < BW; i++) i_fmap[b + i] = v[BW-1-i];
  endtask

  // Accept a map from IDLE, wait for o_valid, check latency and o_bin.
  // Leaves the DUT in DONE.
  task automatic run_map(input string nm);
    int cnt;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    cnt = 1;
    i_valid = 1'b0;
    chk({nm, " busy"}, int'(o_ready), 0);
    while (!o_valid && cnt < 3000) begin
      @(posedge i_clk); #1;
      cnt++;
    end
    chk({nm, " lat"}, cnt, LAT);
    chk_bin({nm, " obin"});
  endtask

  task automatic release_done(input string nm);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk({nm, " rdy"}, int'(o_ready), 1);
    chk({nm, " vld"}, int'(o_valid), 0);
  endtask

  initial begin
    int acc[2];
    int nacc, edges;
    bit pr, ok, sawa;

    vecs[0] = '{"zero_t1",   0, 0, 0,   0, 0, 1,    0, -1};
    vecs[1] = '{"e9_t9",     3, 5, 7,   9, 0, 9,    0, 459};
    vecs[2] = '{"e9_t10",    3, 5, 7,   9, 0, 10,   0, -1};
    vecs[3] = '{"zero_t0",   0, 0, 0,   0, 0, 0,    1, -1};
    vecs[4] = '{"corner255", 9, 23, 23, 255, 0, 255, 0, 1439};
    vecs[5] = '{"thr_max",   9, 23, 23, 255, 0, 1023, 0, -1};
    vecs[6] = '{"msb128",    1, 0, 1, 128, 0, 128,  0, 144};
    vecs[7] = '{"lsb1",      2, 11, 4,  1, 0, 1,    0, 350};
`ifdef POOL1_SUM_EN
    vecs[8] = '{"quad_set",  0, 0, 0,   3, 1, 12,   0, 0};
    vecs[9] = '{"quad_clr",  0, 0, 0,   3, 1, 13,   0, -1};
`else
    vecs[8] = '{"quad_set",  0, 0, 0,   3, 1, 3,    0, 0};
    vecs[9] = '{"quad_clr",  0, 0, 0,   3, 1, 4,    0, -1};
`endif

    i_rst_n = 1'b0;
    i_fmap = '0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_threshold = '0;
    exp_bin = '0;
    #12;
    chk("rst rdy", int'(o_ready), 1);
    chk("rst vld", int'(o_valid), 0);
    chk_bin("rst");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    foreach (vecs[n]) begin
      i_fmap = '0;
      if (vecs[n].quad) begin
        for (int d = 0; d < 4; d++)
          set_elem(vecs[n].c, vecs[n].y + d / 2, vecs[n].x + d % 2, vecs[n].v);
      end else begin
        set_elem(vecs[n].c, vecs[n].y, vecs[n].x, vecs[n].v);
      end
      i_threshold = 10'(vecs[n].thr);
      exp_bin = vecs[n].all1 ? '1 : '0;
      if (vecs[n].eidx >= 0) exp_bin[vecs[n].eidx] = 1'b1;
      run_map(vecs[n].nm);
      release_done(vecs[n].nm);
    end

    // DONE back-pressure: 20 cycles with i_ready low and i_valid pulses.
    i_fmap = '0;
    set_elem(3, 5, 7, 9);
    i_threshold = 10'd9;
    exp_bin = '0;
    exp_bin[459] = 1'b1;
    run_map("hold");
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      i_valid = (i % 2 == 0);
      @(posedge i_clk); #1;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_bin !== exp_bin) ok = 1'b0;
    end
    i_valid = 1'b0;
    chk("hold stable", int'(ok), 1);
    release_done("hold");
    @(posedge i_clk); #1;
    chk("hold no accept", int'(o_ready), 1);

    // Reset at RUN cycle 500 with threshold 0 so o_bin is filling with ones.
    i_fmap = '0;
    i_threshold = '0;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int i = 1; i < 500; i++) begin
      @(posedge i_clk); #1;
    end
    chk("mid run ones", int'($countones(o_bin) >= 400), 1);
    i_rst_n = 1'b0;
    #1;
    exp_bin = '0;
    chk("abort rdy", int'(o_ready), 1);
    chk("abort vld", int'(o_valid), 0);
    chk_bin("abort");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    set_elem(2, 11, 4, 1);
    i_threshold = 10'd1;
    exp_bin[350] = 1'b1;
    run_map("post_rst");
    release_done("post_rst");

    // Back-to-back: map A then map B, i_valid and i_ready held high.
    i_fmap = '0;
    set_elem(0, 0, 0, 5);
    i_threshold = 10'd5;
    i_ready = 1'b1;
    i_valid = 1'b1;
    nacc = 0;
    edges = 0;
    sawa = 1'b0;
    while (edges < 5000) begin
      pr = o_ready;
      @(posedge i_clk); #1;
      edges++;
      if (pr && nacc < 2) begin
        acc[nacc] = edges;
        nacc++;
        if (nacc == 2) i_valid = 1'b0;
      end
      if (o_valid && nacc == 1 && !sawa) begin
        exp_bin = '0;
        exp_bin[0] = 1'b1;
        chk_bin("b2b A");
        sawa = 1'b1;
      end
      if (o_ready && nacc == 1 && sawa) begin
        i_fmap = '0;
        set_elem(9, 23, 23, 5);
      end
      if (o_valid && nacc == 2) break;
    end
    chk("b2b accepts", nacc, 2);
    chk("b2b spacing", acc[1] - acc[0], 1442);
    exp_bin = '0;
    exp_bin[1439] = 1'b1;
    chk_bin("b2b B");
    @(posedge i_clk); #1;
    i_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool1_10.md
# pool1_10

Sequential 2×2 pooling and re-binarization stage directly downstream of the first binary convolution layer. It consumes the 10-channel, 24×24, bW-bit popcount feature map and walks the map one pooled window per cycle. It emits a 10×12×12 binary map, one bit per window, as the input to the second convolution layer. Upstream and downstream are decoupled by valid/ready handshakes.

## Interface
- bW, 8, width of one input feature-map element (unsigned popcount)
- CH, 10, channels
- IN, 24, input map side
- OUT, 12, output map side (IN/2)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_fmap  in  CH\*IN\*IN\*bW  feature map.
  - Element (c,y,x) occupies bits [b : b+bW-1], where b=((c\*IN+y)\*IN+x)\*bW.
  - Bit b is the element's MSB.
- i_valid  in  1  i_fmap valid
- o_ready  out  1  block idle, can accept
- i_threshold  in  bW+2  binarization threshold (unsigned)
- o_bin  out  CH\*OUT\*OUT  binary map; bit index (c\*OUT+r)\*OUT+k
- o_valid  out  1  o_bin complete
- i_ready  in  1  downstream accepts o_bin

## Operation
- States: IDLE, RUN, DONE (shared enum).
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready, clear counters c/r/k to 0 and go to RUN.
- RUN:
  - o_ready=0.
  - Each cycle, evaluate window (c,r,k) over elements (c,2r,2k), (c,2r,2k+1), (c,2r+1,2k), (c,2r+1,2k+1).
  - Compute m = max of the four, zero-extended to bW+2.
  - Register bit = (m >= i_threshold) into o_bin at index (c\*OUT+r)\*OUT+k.
  - Counter order: k fastest, then r, then c.
  - After window (CH-1,OUT-1,OUT-1), go to DONE.
- i_fmap is not captured. Upstream holds i_fmap and i_threshold stable from the accept cycle until o_ready returns high. Changes inside that window are a protocol violation; results are undefined.
- DONE:
  - o_valid=1; o_bin held stable.
  - On i_ready, go to IDLE.
- o_bin keeps its last value in IDLE. It is overwritten bit by bit during the next RUN.
- i_valid in RUN/DONE is ignored (not accepted).
- Threshold 0 sets every bit.
- A threshold above the maximum possible value clears every bit.

## Timing
- Reset values: state IDLE, o_ready=1, o_valid=0, o_bin all 0, counters 0.
- Accept at cycle t; RUN occupies t+1 … t+CH\*OUT\*OUT (t+1440 at defaults).
- o_valid rises at t+1441.
- DONE with i_ready=1 at cycle u:
  - o_valid=0 and o_ready=1 at u+1.
  - Earliest next accept is u+1 (no same-cycle DONE→accept).
- Minimum period per map: 1442 cycles.
- Reset asserted mid-RUN or mid-DONE aborts immediately to reset values. No partial result is flagged.

## Configuration
- POOL1_SUM_EN defined: m = sum of the four elements, bW+2 bits, no overflow. Comparison is unchanged (m >= i_threshold).
- POOL1_SUM_EN undefined: m = max, as above.
- Ports and latency are identical in both builds.

## Structure
- Package pool1_pkg holds:
  - constants CH, IN, OUT, NWIN = CH\*OUT\*OUT;
  - the state enum {IDLE, RUN, DONE};
  - an index function for element base bit and output bit.
- One sub-module, pool1_win: combinational 4-input max (or sum under POOL1_SUM_EN) plus threshold compare. Instantiated once; its inputs are muxed from i_fmap by (c,r,k).
- The top holds the FSM, counters and the o_bin register.

## Test plan
- All-zero i_fmap, threshold 1:
  - o_bin all 0;
  - o_valid exactly 1441 cycles after accept.
- Element (3,5,7)=9, all others 0:
  - threshold 9 → only o_bin bit 459 set;
  - threshold 10 → all 0.
- Hold i_ready low 20 cycles in DONE:
  - o_valid, o_bin stable; o_ready=0;
  - i_valid pulses ignored;
  - after i_ready, o_ready=1 next cycle.
- Back-to-back maps (i_valid held high, i_ready high):
  - accepts spaced exactly 1442 cycles;
  - second o_bin reflects the second map.
- Assert i_rst_n low at RUN cycle 500:
  - o_valid=0, o_bin all 0, o_ready=1 immediately;
  - next accept after release completes normally.
- POOL1_SUM_EN, window (0,0,0) with values 3,3,3,3:
  - threshold 12 → bit 0 set; threshold 13 → bit 0 clear;
  - with the macro undefined, threshold 3 → set, threshold 4 → clear.
